regfile_multiport: RTL and testbench
====================================

Name: regfile_multiport

Overview:
Parametrised multi-port register file, the successor to the single-write 2-read register bank. It provides NUM_RD read ports and two write ports with byte enables. Other features are an optional hardwired zero register, write-to-read bypass, an optional registered-read mode, and a per-register busy scoreboard for pipeline hazard tracking. It sits in the CPU datapath between decode (reads, reservations) and writeback (writes).

Parameters:
ADDR_SIZE, 5, address width; depth = 2**ADDR_SIZE
WORD_SIZE, 32, data width; must be a multiple of 8
NUM_RD, 2, number of read ports (1..4)
ZERO_REG, 1, 1 = register 0 reads 0, ignores writes, is never busy
RD_REG, 0, 0 = combinational read; 1 = read data registered, 1-cycle latency
BYPASS, 1, 1 = reads return data being written in the same cycle

Ports:
clk  in  1  clock, rising edge
reset  in  1  reset, synchronous, active-high
rd_addr  in  NUM_RD*ADDR_SIZE  packed read addresses; port i = slice i
rd_data  out  NUM_RD*WORD_SIZE  packed read data; port i = slice i
rd_busy  out  NUM_RD  busy flag of the register addressed by each read port
wr0_en  in  1  write port 0 enable
wr0_addr  in  ADDR_SIZE  write port 0 address
wr0_be  in  WORD_SIZE/8  write port 0 byte enables
wr0_data  in  WORD_SIZE  write port 0 data
wr1_en, wr1_addr, wr1_be, wr1_data  in  as port 0  write port 1 (higher priority)
rsv_en  in  1  reserve request: mark rsv_addr busy
rsv_addr  in  ADDR_SIZE  register to reserve
busy  out  2**ADDR_SIZE  full scoreboard vector, bit k = register k busy

Behaviour:
- Reset (clk edge with reset=1):
  - All words cleared to 0, including the top entry.
  - busy all 0; registered rd_data 0.
  - Reset overrides any write or reserve in that cycle.
- Write, taken at the rising edge when wrN_en=1:
  - Only bytes with wrN_be[b]=1 are updated. wrN_en=1 with be=0 is a no-op.
- Both ports writing the same address:
  - Per byte, wr1 wins where both be bits are set.
  - Bytes enabled on only one port take that port's data.
  - Different addresses: both writes complete in the same cycle.
- ZERO_REG=1:
  - Writes to address 0 are discarded.
  - Reads of address 0 return 0; busy[0] is held 0 and rsv to 0 is ignored.
- Read, RD_REG=0:
  - rd_data reflects the array combinationally.
  - If BYPASS=1 and an enabled write in the current cycle targets the read address, the result is the merged value. Bytes are taken from the write data (wr1 over wr0) where enabled, and from the stored word elsewhere.
- Read, RD_REG=1:
  - rd_data is sampled at the edge and appears 1 cycle after the address.
  - BYPASS=1: the sample includes the same-edge merged write.
  - BYPASS=0: the sample is the pre-write contents.
- Scoreboard:
  - rsv_en sets busy[rsv_addr] at the edge.
  - Any enabled write clears busy for its address, regardless of be.
  - Reserve and write to the same address in the same cycle: busy ends 1 (new producer wins).
  - rd_busy[i] = busy[rd_addr_i], combinational in both RD_REG modes.
  - BYPASS=1 only: rd_busy is 0 if that register is written this cycle and not re-reserved this cycle.
- No X propagation: out-of-range parameters are rejected at elaboration.

Decomposition:
- Package regfile_pkg:
  - Constant for bytes per word.
  - A byte-merge function (old word, wr0 data/be, wr1 data/be) -> merged word, shared by the array write and the bypass path.
- Sub-module regfile_scoreboard:
  - Holds the busy vector and its reserve/clear/reset logic.
  - Produces the busy and rd_busy outputs.
- The top level holds the array, write merge, read muxes and the optional output register.

Test Plan:
- Reset, then read all 32 addresses -> every rd_data = 0, busy = 0. Includes address 31 and a write issued in the reset cycle.
- Dual-write collision: wr0 addr 5 data 0xAAAAAAAA be 0xF and wr1 addr 5 data 0x55555555 be 0x3 in the same cycle -> reg5 = 0xAAAA5555.
- ZERO_REG=1: write 0xDEADBEEF to addr 0 and rsv addr 0 -> rd_data = 0 and busy[0] = 0. With ZERO_REG=0 the same stimulus -> read 0xDEADBEEF.
- Bypass, RD_REG=0 BYPASS=1:
  - Setup: reg7 = 0x11223344.
  - Stimulus: write wr0 addr 7 data 0xFFFFFFFF be 0x1 while reading addr 7.
  - Required: same-cycle rd_data = 0x112233FF. With BYPASS=0 -> 0x11223344, then 0x112233FF next cycle.
- RD_REG=1: addr change to 9 (reg9 = 0x9) -> rd_data updates exactly one edge later. Same-edge write to 9 with BYPASS=1 -> new value appears at that edge.
- Scoreboard:
  - rsv addr 3 -> busy[3]=1 next cycle, rd_busy=1 for reads of 3.
  - wr0 to 3 alone -> busy[3]=0.
  - rsv and write to 3 in the same cycle -> busy[3] stays 1.
  - Reset mid-reservation -> busy all 0.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared constants and the byte-merge rule used by the array write and the read bypass.
// Combinational helpers only, so there is no latency and no backpressure.
package regfile_pkg;

   localparam int BYTE_BITS = 8;
   localparam int MAX_WORD  = 128;
   localparam int MAX_BYTES = MAX_WORD / BYTE_BITS;

   function automatic int bytes_per_word(input int word_bits);
      return word_bits / BYTE_BITS;
   endfunction

   // wr1 is applied after wr0, so it wins on any byte that both ports enable.
   function automatic logic [MAX_WORD-1:0] merge_bytes(
      input logic [MAX_WORD-1:0]  old_word,
      input logic [MAX_WORD-1:0]  d0,
      input logic [MAX_BYTES-1:0] be0,
      input logic [MAX_WORD-1:0]  d1,
      input logic [MAX_BYTES-1:0] be1
   );
      logic [MAX_WORD-1:0] w;
      w = old_word;
      for (int b = 0; b < MAX_BYTES; b++) begin
         if (be0[b]) w[b*BYTE_BITS +: BYTE_BITS] = d0[b*BYTE_BITS +: BYTE_BITS];
         if (be1[b]) w[b*BYTE_BITS +: BYTE_BITS] = d1[b*BYTE_BITS +: BYTE_BITS];
      end
      return w;
   endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy scoreboard: reserve sets a bit, any write to the register clears it.
// State updates at the clock edge; rd_busy is combinational; there is no backpressure.
module regfile_scoreboard #(
   parameter int ADDR_SIZE = 5,
   parameter int NUM_RD    = 2,
   parameter int ZERO_REG  = 1,
   parameter int BYPASS    = 1
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [NUM_RD*ADDR_SIZE-1:0]   rd_addr,
   input  logic                          wr0_en,
   input  logic [ADDR_SIZE-1:0]          wr0_addr,
   input  logic                          wr1_en,
   input  logic [ADDR_SIZE-1:0]          wr1_addr,
   input  logic                          rsv_en,
   input  logic [ADDR_SIZE-1:0]          rsv_addr,
   output logic [(1<<ADDR_SIZE)-1:0]     busy,
   output logic [NUM_RD-1:0]             rd_busy
);

   localparam int DEPTH = 1 << ADDR_SIZE;

   logic [DEPTH-1:0] busy_q;
   logic [DEPTH-1:0] busy_nxt;

   // Reserve is applied last so a new producer outranks a completing one.
   always_comb begin
      busy_nxt = busy_q;
      if (wr0_en) busy_nxt[wr0_addr] = 1'b0;
      if (wr1_en) busy_nxt[wr1_addr] = 1'b0;
      if (rsv_en) busy_nxt[rsv_addr] = 1'b1;
      if (ZERO_REG != 0) busy_nxt[0] = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (reset) busy_q <= '0;
      else       busy_q <= busy_nxt;
   end

   assign busy = busy_q;

   for (genvar i = 0; i < NUM_RD; i++) begin : g_rd_busy
      logic [ADDR_SIZE-1:0] a;
      logic                 written;
      logic                 rereserved;
      assign a          = rd_addr[i*ADDR_SIZE +: ADDR_SIZE];
      assign written    = (wr0_en && wr0_addr == a) || (wr1_en && wr1_addr == a);
      assign rereserved = rsv_en && rsv_addr == a;
      assign rd_busy[i] = busy_q[a] && !(BYPASS != 0 && written && !rereserved);
   end

endmodule

// File: rtl/regfile_multiport.sv
// Multi-port register file: NUM_RD reads, two byte-enabled writes (wr1 wins), busy scoreboard.
// Reads are combinational or 1-cycle when RD_REG=1; writes land at the edge; no backpressure.
module regfile_multiport
   import regfile_pkg::*;
#(
   parameter int ADDR_SIZE = 5,
   parameter int WORD_SIZE = 32,
   parameter int NUM_RD    = 2,
   parameter int ZERO_REG  = 1,
   parameter int RD_REG    = 0,
   parameter int BYPASS    = 1
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [NUM_RD*ADDR_SIZE-1:0]   rd_addr,
   output logic [NUM_RD*WORD_SIZE-1:0]   rd_data,
   output logic [NUM_RD-1:0]             rd_busy,
   input  logic                          wr0_en,
   input  logic [ADDR_SIZE-1:0]          wr0_addr,
   input  logic [WORD_SIZE/8-1:0]        wr0_be,
   input  logic [WORD_SIZE-1:0]          wr0_data,
   input  logic                          wr1_en,
   input  logic [ADDR_SIZE-1:0]          wr1_addr,
   input  logic [WORD_SIZE/8-1:0]        wr1_be,
   input  logic [WORD_SIZE-1:0]          wr1_data,
   input  logic                          rsv_en,
   input  logic [ADDR_SIZE-1:0]          rsv_addr,
   output logic [(1<<ADDR_SIZE)-1:0]     busy
);

   localparam int DEPTH = 1 << ADDR_SIZE;
   localparam int NB    = bytes_per_word(WORD_SIZE);

   if (WORD_SIZE < BYTE_BITS || WORD_SIZE > MAX_WORD || WORD_SIZE % BYTE_BITS != 0) begin : g_bad_word
      $error("regfile_multiport: WORD_SIZE must be a multiple of 8 in 8..%0d", MAX_WORD);
   end
   if (NUM_RD < 1 || NUM_RD > 4) begin : g_bad_num_rd
      $error("regfile_multiport: NUM_RD must be 1..4");
   end
   if (ADDR_SIZE < 1 || ADDR_SIZE > 16) begin : g_bad_addr
      $error("regfile_multiport: ADDR_SIZE must be 1..16");
   end
   if (ZERO_REG < 0 || ZERO_REG > 1 || RD_REG < 0 || RD_REG > 1 || BYPASS < 0 || BYPASS > 1) begin : g_bad_flag
      $error("regfile_multiport: ZERO_REG, RD_REG and BYPASS must be 0 or 1");
   end

   function automatic logic [WORD_SIZE-1:0] merge_w(
      input logic [WORD_SIZE-1:0] old_word,
      input logic [WORD_SIZE-1:0] d0,
      input logic [NB-1:0]        b0,
      input logic [WORD_SIZE-1:0] d1,
      input logic [NB-1:0]        b1
   );
      return WORD_SIZE'(merge_bytes(MAX_WORD'(old_word), MAX_WORD'(d0), MAX_BYTES'(b0),
                                    MAX_WORD'(d1), MAX_BYTES'(b1)));
   endfunction

   logic [WORD_SIZE-1:0] mem [DEPTH];
   logic                 wr0_act;
   logic                 wr1_act;

   // Writes to the hardwired zero register never reach the array or the bypass.
   assign wr0_act = wr0_en && !(ZERO_REG != 0 && wr0_addr == '0);
   assign wr1_act = wr1_en && !(ZERO_REG != 0 && wr1_addr == '0);

   always_ff @(posedge clk) begin
      for (int k = 0; k < DEPTH; k++) begin
         if (reset) begin
            mem[k] <= '0;
         end else begin
            mem[k] <= merge_w(mem[k],
                              wr0_data, (wr0_act && wr0_addr == ADDR_SIZE'(k)) ? wr0_be : '0,
                              wr1_data, (wr1_act && wr1_addr == ADDR_SIZE'(k)) ? wr1_be : '0);
         end
      end
   end

   for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
      logic [ADDR_SIZE-1:0] a;
      logic [NB-1:0]        byp0;
      logic [NB-1:0]        byp1;
      logic [WORD_SIZE-1:0] v;

      assign a    = rd_addr[i*ADDR_SIZE +: ADDR_SIZE];
      assign byp0 = (BYPASS != 0 && wr0_act && wr0_addr == a) ? wr0_be : '0;
      assign byp1 = (BYPASS != 0 && wr1_act && wr1_addr == a) ? wr1_be : '0;
      assign v    = (ZERO_REG != 0 && a == '0) ? '0 : merge_w(mem[a], wr0_data, byp0, wr1_data, byp1);

      if (RD_REG != 0) begin : g_reg
         logic [WORD_SIZE-1:0] q;
         always_ff @(posedge clk) begin
            if (reset) q <= '0;
            else       q <= v;
         end
         assign rd_data[i*WORD_SIZE +: WORD_SIZE] = q;
      end else begin : g_comb
         assign rd_data[i*WORD_SIZE +: WORD_SIZE] = v;
      end
   end

   regfile_scoreboard #(
      .ADDR_SIZE (ADDR_SIZE),
      .NUM_RD    (NUM_RD),
      .ZERO_REG  (ZERO_REG),
      .BYPASS    (BYPASS)
   ) u_scoreboard (
      .clk      (clk),
      .reset    (reset),
      .rd_addr  (rd_addr),
      .wr0_en   (wr0_en),
      .wr0_addr (wr0_addr),
      .wr1_en   (wr1_en),
      .wr1_addr (wr1_addr),
      .rsv_en   (rsv_en),
      .rsv_addr (rsv_addr),
      .busy     (busy),
      .rd_busy  (rd_busy)
   );

endmodule

// File: tb/tb_regfile_multiport.sv
// Bench for regfile_multiport: four parameter variants driven by shared stimulus,
// checked against an array-level reference model plus directed literal expectations.
module tb_regfile_multiport;

   localparam int AW = 5;
   localparam int DW = 32;
   localparam int NR = 2;
   localparam int NB = 4;
   localparam int DEPTH = 32;
   localparam int NI = 4;
   // Per-instance configuration, bit g = instance g.
   localparam logic [NI-1:0] CZ = 4'b0101;
   localparam logic [NI-1:0] CB = 4'b0101;
   localparam logic [NI-1:0] CR = 4'b1100;

   logic clk = 1'b0;
   logic reset;
   logic [AW-1:0] ra [NR];
   logic [NR*AW-1:0] rd_addr;
   logic wr0_en, wr1_en, rsv_en;
   logic [AW-1:0] wr0_addr, wr1_addr, rsv_addr;
   logic [NB-1:0] wr0_be, wr1_be;
   logic [DW-1:0] wr0_data, wr1_data;

   logic [NR*DW-1:0] rdd [NI];
   logic [NR-1:0]    rdb [NI];
   logic [DEPTH-1:0] bsy [NI];

   assign rd_addr = {ra[1], ra[0]};

   initial forever #5 clk = ~clk;

   for (genvar g = 0; g < NI; g++) begin : g_dut
      regfile_multiport #(
         .ADDR_SIZE (AW), .WORD_SIZE (DW), .NUM_RD (NR),
         .ZERO_REG  (CZ[g] ? 1 : 0), .RD_REG (CR[g] ? 1 : 0), .BYPASS (CB[g] ? 1 : 0)
      ) u_dut (
         .clk (clk), .reset (reset), .rd_addr (rd_addr), .rd_data (rdd[g]), .rd_busy (rdb[g]),
         .wr0_en (wr0_en), .wr0_addr (wr0_addr), .wr0_be (wr0_be), .wr0_data (wr0_data),
         .wr1_en (wr1_en), .wr1_addr (wr1_addr), .wr1_be (wr1_be), .wr1_data (wr1_data),
         .rsv_en (rsv_en), .rsv_addr (rsv_addr), .busy (bsy[g])
      );
   end

   // Reference model: set 0 = zero-register variants, set 1 = plain variants.
   logic [DW-1:0]    m_mem  [2][DEPTH];
   logic [DEPTH-1:0] m_busy [2];
   logic [DW-1:0]    m_q    [NI][NR];
   bit model_valid = 0;
   int tests = 0;
   int failed = 0;

   function automatic logic [DW-1:0] apply_writes(input logic [DW-1:0] old, input logic [AW-1:0] k, input bit z);
      logic [DW-1:0] w;
      w = old;
      if (z && k == 0) return old;
      for (int b = 0; b < NB; b++) begin
         if (wr0_en && wr0_addr == k && wr0_be[b]) w[b*8 +: 8] = wr0_data[b*8 +: 8];
         if (wr1_en && wr1_addr == k && wr1_be[b]) w[b*8 +: 8] = wr1_data[b*8 +: 8];
      end
      return w;
   endfunction

   function automatic bit written(input logic [AW-1:0] k);
      return (wr0_en && wr0_addr == k) || (wr1_en && wr1_addr == k);
   endfunction

   function automatic logic [DW-1:0] exp_read(input int inst, input logic [AW-1:0] k);
      logic [DW-1:0] w;
      int s;
      s = CZ[inst] ? 0 : 1;
      w = m_mem[s][k];
      if (CB[inst]) w = apply_writes(w, k, CZ[inst]);
      if (CZ[inst] && k == 0) w = '0;
      return w;
   endfunction

   function automatic bit exp_busy(input int inst, input logic [AW-1:0] k);
      bit b;
      b = m_busy[CZ[inst] ? 0 : 1][k];
      if (CB[inst] && written(k) && !(rsv_en && rsv_addr == k)) b = 1'b0;
      return b;
   endfunction

   task automatic model_update();
      if (reset) begin
         for (int s = 0; s < 2; s++) begin
            m_busy[s] = '0;
            for (int k = 0; k < DEPTH; k++) m_mem[s][k] = '0;
         end
         for (int g = 0; g < NI; g++) for (int p = 0; p < NR; p++) m_q[g][p] = '0;
      end else begin
         for (int g = 0; g < NI; g++) for (int p = 0; p < NR; p++) m_q[g][p] = exp_read(g, ra[p]);
         for (int s = 0; s < 2; s++) begin
            for (int k = 0; k < DEPTH; k++) begin
               m_mem[s][k] = apply_writes(m_mem[s][k], AW'(k), s == 0);
               if (written(AW'(k))) m_busy[s][k] = 1'b0;
               if (rsv_en && rsv_addr == AW'(k)) m_busy[s][k] = 1'b1;
            end
            if (s == 0) m_busy[s][0] = 1'b0;
         end
      end
   endtask

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      tests++;
      assert (got === exp) else begin
         failed++;
         $error("FAIL %s observed=%h expected=%h", tag, got, exp);
      end
   endtask

   task automatic check_all();
      logic [DW-1:0] e;
      for (int g = 0; g < NI; g++) begin
         for (int p = 0; p < NR; p++) begin
            e = CR[g] ? m_q[g][p] : exp_read(g, ra[p]);
            chk($sformatf("model_rd_i%0d_p%0d", g, p), 64'(rdd[g][p*DW +: DW]), 64'(e));
            chk($sformatf("model_rdbusy_i%0d_p%0d", g, p), 64'(rdb[g][p]), 64'(exp_busy(g, ra[p])));
         end
         chk($sformatf("model_busy_i%0d", g), 64'(bsy[g]), 64'(m_busy[CZ[g] ? 0 : 1]));
      end
   endtask

   task automatic sample();
      @(negedge clk);
      if (model_valid && !reset) check_all();
   endtask

   task automatic advance();
      model_update();
      @(posedge clk);
      #1;
   endtask

   task automatic tick();
      sample();
      advance();
   endtask

   task automatic idle();
      reset = 1'b0;
      wr0_en = 0; wr0_addr = '0; wr0_be = '0; wr0_data = '0;
      wr1_en = 0; wr1_addr = '0; wr1_be = '0; wr1_data = '0;
      rsv_en = 0; rsv_addr = '0;
   endtask

   task automatic wr0(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [NB-1:0] be);
      wr0_en = 1; wr0_addr = a; wr0_data = d; wr0_be = be;
   endtask

   function automatic logic [AW-1:0] rnd_addr();
      if ($urandom_range(0, 3) == 0) return AW'($urandom_range(0, DEPTH-1));
      return AW'($urandom_range(0, 7));
   endfunction

   initial begin
      idle();
      ra[0] = '0; ra[1] = '0;
      // Reset cycles, with a write and reserve to the top entry that reset must override.
      reset = 1'b1;
      wr0(5'd31, 32'hFFFF_FFFF, 4'hF);
      rsv_en = 1; rsv_addr = 5'd31;
      advance();
      model_valid = 1;
      advance();
      idle();
      for (int k = 0; k < DEPTH; k++) begin
         ra[0] = AW'(k); ra[1] = AW'(DEPTH-1-k);
         sample();
         chk("rst_rd0", 64'(rdd[0][DW-1:0]), 64'h0);
         chk("rst_rd1_plain", 64'(rdd[1][2*DW-1:DW]), 64'h0);
         advance();
      end
      chk("rst_busy", 64'(bsy[0]), 64'h0);

      // Dual-write collision on register 5.
      idle(); ra[0] = 5'd5; ra[1] = 5'd0;
      wr0(5'd5, 32'hAAAA_AAAA, 4'hF);
      wr1_en = 1; wr1_addr = 5'd5; wr1_data = 32'h5555_5555; wr1_be = 4'h3;
      sample();
      chk("coll_bypass", 64'(rdd[0][DW-1:0]), 64'hAAAA_5555);
      advance();
      idle(); sample();
      chk("coll_stored", 64'(rdd[0][DW-1:0]), 64'hAAAA_5555);
      chk("coll_stored_nobyp", 64'(rdd[1][DW-1:0]), 64'hAAAA_5555);
      advance();

      // Zero register vs plain register 0.
      idle(); ra[0] = 5'd0;
      wr0(5'd0, 32'hDEAD_BEEF, 4'hF); rsv_en = 1; rsv_addr = 5'd0;
      tick();
      idle(); sample();
      chk("zero_rd", 64'(rdd[0][DW-1:0]), 64'h0);
      chk("zero_busy", 64'(bsy[0][0]), 64'h0);
      chk("nonzero_rd", 64'(rdd[1][DW-1:0]), 64'hDEAD_BEEF);
      chk("nonzero_busy", 64'(bsy[1][0]), 64'h1);
      advance();

      // Byte-enabled bypass on register 7.
      idle(); wr0(5'd7, 32'h1122_3344, 4'hF); tick();
      idle(); ra[0] = 5'd7; wr0(5'd7, 32'hFFFF_FFFF, 4'h1);
      sample();
      chk("bypass_same", 64'(rdd[0][DW-1:0]), 64'h1122_33FF);
      chk("nobypass_same", 64'(rdd[1][DW-1:0]), 64'h1122_3344);
      advance();
      idle(); sample();
      chk("nobypass_next", 64'(rdd[1][DW-1:0]), 64'h1122_33FF);
      advance();

      // Registered read latency on register 9.
      idle(); ra[0] = 5'd5; wr0(5'd9, 32'h9, 4'hF); tick();
      idle(); ra[0] = 5'd9; sample();
      chk("rr_old", 64'(rdd[2][DW-1:0]), 64'hAAAA_5555);
      advance();
      sample();
      chk("rr_new", 64'(rdd[2][DW-1:0]), 64'h9);
      advance();
      wr0(5'd9, 32'h99, 4'hF); tick();
      idle(); sample();
      chk("rr_bypass_edge", 64'(rdd[2][DW-1:0]), 64'h99);
      chk("rr_nobypass_edge", 64'(rdd[3][DW-1:0]), 64'h9);
      advance();
      sample();
      chk("rr_nobypass_next", 64'(rdd[3][DW-1:0]), 64'h99);
      advance();

      // Scoreboard on register 3.
      idle(); ra[0] = 5'd3; rsv_en = 1; rsv_addr = 5'd3; tick();
      idle(); sample();
      chk("sb_set", 64'(bsy[0][3]), 64'h1);
      chk("sb_rd_busy", 64'(rdb[0][0]), 64'h1);
      advance();
      wr0(5'd3, 32'h0, 4'h0);
      sample();
      chk("sb_rd_busy_bypass", 64'(rdb[0][0]), 64'h0);
      chk("sb_rd_busy_nobypass", 64'(rdb[1][0]), 64'h1);
      advance();
      idle(); sample();
      chk("sb_clear", 64'(bsy[0][3]), 64'h0);
      advance();
      rsv_en = 1; rsv_addr = 5'd3; wr1_en = 1; wr1_addr = 5'd3; wr1_be = 4'hF; wr1_data = 32'h33;
      tick();
      idle(); sample();
      chk("sb_rsv_wins", 64'(bsy[0][3]), 64'h1);
      advance();
      rsv_en = 1; rsv_addr = 5'd4; tick();
      idle(); reset = 1'b1; tick();
      idle(); sample();
      chk("sb_reset_i0", 64'(bsy[0]), 64'h0);
      chk("sb_reset_i1", 64'(bsy[1]), 64'h0);
      advance();

      // Randomised traffic biased towards a few addresses to provoke collisions.
      for (int n = 0; n < 400; n++) begin
         reset    = ($urandom_range(0, 63) == 0);
         wr0_en   = 1'($urandom_range(0, 1));
         wr0_addr = rnd_addr();
         wr0_be   = 4'($urandom);
         wr0_data = $urandom;
         wr1_en   = 1'($urandom_range(0, 1));
         wr1_addr = rnd_addr();
         wr1_be   = 4'($urandom);
         wr1_data = $urandom;
         rsv_en   = 1'($urandom_range(0, 1));
         rsv_addr = rnd_addr();
         ra[0]    = rnd_addr();
         ra[1]    = rnd_addr();
         tick();
      end

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
